// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg
// One-deep elastic pipeline register between two instruction pipeline
// stages. It has valid/ready handshakes on both sides, an optional skid
// entry, a flush that kills every held entry, and a saturating counter
// of bubble cycles.
//
// Parameters
//   DATA_W : payload width (data fields concatenated by the instantiating stage)
//   CTRL_W : control field width; this field is zero in every bubble
//   SKID   : 1 = two entries with registered in_ready,
//            0 = one entry with combinational in_ready
//   CNT_W  : bubble counter width
//
// Ports
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : upstream handshake
//   in_ctrl/in_data       : upstream control bits and payload
//   flush                 : drop all held entries; the input in this cycle is discarded
//   out_valid/out_ready   : downstream handshake
//   out_ctrl/out_data     : head entry (ctrl is zero when out_valid = 0)
//   bubble_cnt            : saturating count of edges seen with out_valid = 0
module elastic_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              in_ready_q,   in_ready_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic accept;
  logic consume;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // With a skid entry, in_ready is a flop. Without one, the single entry
  // can accept in the same cycle that it drains.
  assign in_ready = (SKID != 0) ? in_ready_q : (~main_valid_q | out_ready);

  assign accept  = in_valid & in_ready;
  assign consume = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      // Flush wins over acceptance. A completed upstream handshake is lost.
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
    end else if (SKID != 0) begin
      if (main_valid_q && !consume) begin
        // The head is stalled. The skid entry must be empty here because
        // in_ready was low otherwise.
        if (accept) begin
          skid_valid_d = 1'b1;
          skid_ctrl_d  = in_ctrl;
          skid_data_d  = in_data;
        end
      end else if (skid_valid_q) begin
        // The head drains and the skid entry moves forward. No accept is
        // possible this cycle because in_ready = ~skid_valid.
        main_valid_d = 1'b1;
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
        skid_ctrl_d  = '0;
      end else begin
        main_valid_d = accept;
        main_ctrl_d  = accept ? in_ctrl : '0;
        if (accept) begin
          main_data_d = in_data;
        end
      end
    end else begin
      if (!main_valid_q || consume) begin
        main_valid_d = accept;
        main_ctrl_d  = accept ? in_ctrl : '0;
        if (accept) begin
          main_data_d = in_data;
        end
      end
    end

    in_ready_d = ~skid_valid_d;

    bubble_cnt_d = bubble_cnt_q;
    if (!main_valid_q && (bubble_cnt_q != CNT_MAX)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
      bubble_cnt_q <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= (SKID != 0) ? skid_valid_d : 1'b0;
      skid_ctrl_q  <= (SKID != 0) ? skid_ctrl_d : '0;
      skid_data_q  <= (SKID != 0) ? skid_data_d : '0;
      in_ready_q   <= in_ready_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign out_valid  = main_valid_q;
  assign out_ctrl   = main_ctrl_q;
  assign out_data   = main_data_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Testbench for elastic_pipe_reg. It drives three instances from one shared stimulus:
//   u_skid  : defaults (SKID=1, CNT_W=16)
//   u_flow  : SKID=0
//   u_cnt4  : SKID=1, CNT_W=4
// Each instance is compared against a queue model of a capacity-limited
// FIFO: head on the outputs, flush empties it, and a bubble is counted
// per edge while the queue is empty.
module tb_elastic_pipe_reg;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_ctrl;
  logic [31:0] in_data;
  logic        flush;
  logic        out_ready;

  logic        rdy [3];
  logic        ov  [3];
  logic [3:0]  oc  [3];
  logic [31:0] od  [3];
  logic [15:0] bc0, bc1;
  logic [3:0]  bc2;

  int errors = 0;
  int checks = 0;

  // reference model state
  int          cnt  [3];
  logic [35:0] ent  [3][2];
  int          bub  [3];
  int          bmax [3];
  bit          sk   [3];

  elastic_pipe_reg u_skid (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(ov[0]), .out_ready(out_ready), .out_ctrl(oc[0]),
    .out_data(od[0]), .bubble_cnt(bc0));

  elastic_pipe_reg #(.SKID(0)) u_flow (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(ov[1]), .out_ready(out_ready), .out_ctrl(oc[1]),
    .out_data(od[1]), .bubble_cnt(bc1));

  elastic_pipe_reg #(.SKID(1), .CNT_W(4)) u_cnt4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(ov[2]), .out_ready(out_ready), .out_ctrl(oc[2]),
    .out_data(od[2]), .bubble_cnt(bc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int i, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  function automatic logic [63:0] bub_obs(input int i);
    if (i == 0) return {48'd0, bc0};
    if (i == 1) return {48'd0, bc1};
    return {60'd0, bc2};
  endfunction

  function automatic bit exp_ready(input int i);
    if (sk[i]) return cnt[i] < 2;
    return (cnt[i] == 0) || out_ready;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 0;
      bub[i] = 0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk("in_ready", i, {63'd0, rdy[i]}, {63'd0, exp_ready(i)});
      chk("out_valid", i, {63'd0, ov[i]}, {63'd0, cnt[i] > 0});
      chk("out_ctrl", i, {60'd0, oc[i]}, (cnt[i] > 0) ? {60'd0, ent[i][0][35:32]} : 64'd0);
      if (cnt[i] > 0)
        chk("out_data", i, {32'd0, od[i]}, {32'd0, ent[i][0][31:0]});
      chk("bubble_cnt", i, bub_obs(i), 64'(bub[i]));
    end
  endtask

  // Apply one rising edge to the model, using the inputs currently driven.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      bit ir;
      ir = exp_ready(i);
      if (cnt[i] == 0 && bub[i] < bmax[i]) bub[i]++;
      if (flush) begin
        cnt[i] = 0;
      end else begin
        if (cnt[i] > 0 && out_ready) begin
          ent[i][0] = ent[i][1];
          cnt[i]--;
        end
        if (in_valid && ir) begin
          ent[i][cnt[i]] = {in_ctrl, in_data};
          cnt[i]++;
        end
      end
    end
  endtask

  // Called at a falling edge: drive the inputs, check, advance one cycle.
  task automatic step(input logic v, input logic [31:0] d, input logic [3:0] c,
                      input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_all();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    sk[0] = 1'b1; sk[1] = 1'b0; sk[2] = 1'b1;
    bmax[0] = 65535; bmax[1] = 65535; bmax[2] = 15;
    for (int i = 0; i < 3; i++) begin
      ent[i][0] = '0;
      ent[i][1] = '0;
    end
    model_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_ctrl = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_all();
    for (int i = 0; i < 3; i++) chk("reset_data", i, {32'd0, od[i]}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    // This edge was idle, with rst deasserted and the model empty.
    for (int i = 0; i < 3; i++) bub[i] = 1;

    // Single transfer with one-cycle latency.
    step(1'b1, 32'h10, 4'h5, 1'b1, 1'b0);
    chk("lat1_data", 0, {32'd0, od[0]}, 64'h10);
    chk("lat1_ctrl", 0, {60'd0, oc[0]}, 64'h5);
    step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);

    // Stall with skid fill: A goes to main, B goes to skid, C waits upstream. Then drain.
    step(1'b1, 32'h1, 4'h1, 1'b0, 1'b0);
    step(1'b1, 32'h2, 4'h2, 1'b0, 1'b0);
    chk("skid_full_ready", 0, {63'd0, rdy[0]}, 64'd0);
    step(1'b1, 32'h3, 4'h3, 1'b0, 1'b0);
    step(1'b1, 32'h3, 4'h3, 1'b1, 1'b0);
    step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);

    // Flush with two entries held and a new input offered.
    step(1'b1, 32'h7, 4'h7, 1'b0, 1'b0);
    step(1'b1, 32'h8, 4'h8, 1'b0, 1'b0);
    step(1'b1, 32'h4, 4'h9, 1'b0, 1'b1);
    chk("flush_valid", 0, {63'd0, ov[0]}, 64'd0);
    chk("flush_ctrl", 0, {60'd0, oc[0]}, 64'd0);
    repeat (3) step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);

    // Full throughput for 100 cycles.
    for (int k = 0; k < 100; k++) begin
      logic [31:0] d;
      d = 32'h1000 + 32'(k);
      step(1'b1, d, d[3:0], 1'b1, 1'b0);
    end
    repeat (3) step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);

    // Asynchronous reset pulse between edges while out_valid = 1.
    step(1'b1, 32'hABCD, 4'hC, 1'b0, 1'b0);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("arst_valid", i, {63'd0, ov[i]}, 64'd0);
      chk("arst_ctrl", i, {60'd0, oc[i]}, 64'd0);
      chk("arst_bubble", i, bub_obs(i), 64'd0);
    end
    #1 rst = 1'b0;
    model_reset();
    model_edge();
    @(posedge clk);
    @(negedge clk);

    // Idle after reset: the 4-bit counter saturates at 15.
    repeat (20) step(1'b0, 32'h0, 4'h0, 1'($urandom_range(0, 1)), 1'b0);
    chk("bub_sat", 2, {60'd0, bc2}, 64'd15);
    step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    chk("bub_hold", 2, {60'd0, bc2}, 64'd15);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, 4'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/elastic_pipe_reg.md
ELASTIC_PIPE_REG -- requirements
Module: elastic_pipe_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning payload width in bits (data fields: ALU result, store data, PC+4, rd, concatenated by the instantiating stage).
REQ-002 SHALL have parameter CTRL_W, default 4, meaning width of the control field (RegWrite, ResultSrc, MemWrite) that is forced to zero in bubbles.
REQ-003 SHALL have parameter SKID, default 1, meaning 1 = two-entry skid buffer with registered in_ready, 0 = single entry with combinational in_ready.
REQ-004 SHALL have parameter CNT_W, default 16, meaning width of the bubble performance counter.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  upstream stage holds a valid instruction.
REQ-008 in_ready  output  1  this stage accepts on in_valid && in_ready.
REQ-009 in_ctrl  input  CTRL_W  upstream control bits.
REQ-010 in_data  input  DATA_W  upstream payload.
REQ-011 flush  input  1  kill every held entry (branch mispredict / exception).
REQ-012 out_valid  output  1  output entry valid.
REQ-013 out_ready  input  1  downstream consumes on out_valid && out_ready.
REQ-014 out_ctrl  output  CTRL_W  control bits of the head entry; zero when out_valid=0.
REQ-015 out_data  output  DATA_W  payload of the head entry; don't-care when out_valid=0.
REQ-016 bubble_cnt  output  CNT_W  saturating count of cycles with out_valid=0 since reset.

Function
REQ-017 Storage SHALL be a main entry (valid, ctrl, data) driving the outputs, plus a skid entry when SKID=1; all outputs SHALL be driven from registers, except in_ready when SKID=0.
REQ-018 Latency SHALL be exactly one cycle: an item accepted at edge N appears on out_* after edge N when the main entry is empty or drained at edge N.
REQ-019 SKID=1: in_ready SHALL equal ~skid_valid, registered; it SHALL NOT depend on out_ready combinationally.
REQ-020 SKID=1: when an item is accepted while the main entry is valid and not consumed, the item SHALL go to the skid entry; when the main entry is consumed and the skid entry is valid, the skid entry SHALL move to the main entry in the same edge.
REQ-021 SKID=1: simultaneous accept and consume with the skid entry empty SHALL load the input directly into the main entry (throughput 1 item/cycle).
REQ-022 SKID=0: in_ready SHALL equal ~main_valid | out_ready.
REQ-023 Order SHALL be preserved; no item SHALL be duplicated or dropped except by flush.
REQ-024 While out_valid=1 and out_ready=0, out_ctrl and out_data SHALL remain stable.
REQ-025 flush=1 at an edge SHALL clear main_valid and skid_valid and zero the stored ctrl fields; flush SHALL have priority over acceptance, and in_valid in that cycle SHALL be discarded.
REQ-026 During a flush cycle, in_ready SHALL still follow REQ-019/022; the upstream handshake SHALL complete, and the item SHALL be lost.
REQ-027 out_ctrl SHALL be zero whenever out_valid=0, including after flush and reset.
REQ-028 bubble_cnt SHALL increment by 1 at each edge where out_valid=0 and SHALL saturate at 2^CNT_W-1; flush SHALL NOT clear it.

Reset
REQ-029 On rst=1, asynchronously: main_valid=0, skid_valid=0, out_valid=0, out_ctrl=0, out_data=0, bubble_cnt=0; SKID=1 in_ready=1.
REQ-030 Reset asserted mid-transfer SHALL drop all held entries; the first edge after deassertion SHALL behave as if the block were empty.

Verification
REQ-031 Reset, then in_valid=1, in_data=0x00000010, in_ctrl=0x5, out_ready=1 -> next cycle out_valid=1, out_data=0x10, out_ctrl=0x5.
REQ-032 SKID=1, stream A=0x1, B=0x2, C=0x3 with out_ready=0 from cycle 1 -> A in main, B in skid, in_ready=0, C held upstream; out_ready=1 -> outputs A, B, C on consecutive cycles.
REQ-033 Two entries held, flush=1 with in_valid=1 (data 0x4) -> next cycle out_valid=0, out_ctrl=0, 0x4 never appears.
REQ-034 Continuous in_valid=1 and out_ready=1 for 100 cycles (SKID=0 and SKID=1) -> 100 items out in order, in_ready constantly 1.
REQ-035 CNT_W=4, idle for 20 cycles after reset -> bubble_cnt=15, held at 15.
REQ-036 rst pulsed asynchronously between edges with out_valid=1 -> out_valid, out_ctrl, bubble_cnt read 0 immediately, before the next edge.
